// File: rtl/conv_out_pkg.sv
// Shared types and sizing helpers for the convolution output pipe.
// Typedefs describe the default engine geometry (24 cores x 8 units x 25-bit words).
package conv_out_pkg;

    localparam int WORD_WIDTH_DEF     = 25;
    localparam int CONV_CORES_DEF     = 24;
    localparam int CONV_UNITS_DEF     = 8;
    localparam int TUSER_WIDTH_DEF    = 4;

    typedef logic signed [WORD_WIDTH_DEF-1:0] word_t;

    typedef struct packed {
        logic [CONV_CORES_DEF-1:0][CONV_UNITS_DEF-1:0][WORD_WIDTH_DEF-1:0] data;
        logic                                                              last;
        logic [TUSER_WIDTH_DEF-1:0]                                        user;
    } slot_t;

    function automatic int calc_beats(input int cores, input int per_beat);
        return cores / per_beat;
    endfunction

endpackage

// File: rtl/conv_beat_mux.sv
// Picks CORES_PER_BEAT consecutive cores (core 0 first) out of an engine array by beat index.
// Purely combinational; an out-of-range beat index yields zero.
module conv_beat_mux
    import conv_out_pkg::*;
#(
    parameter int CORES      = 24,
    parameter int UNITS      = 8,
    parameter int WORD_WIDTH = 25,
    parameter int PER_BEAT   = 4,
    parameter int BEAT_W     = 3
) (
    input  logic [CORES-1:0][UNITS-1:0][WORD_WIDTH-1:0]    data,
    input  logic [BEAT_W-1:0]                              beat,
    output logic [PER_BEAT-1:0][UNITS-1:0][WORD_WIDTH-1:0] sel
);

    localparam int BEATS = calc_beats(CORES, PER_BEAT);

    always_comb begin
        sel = '0;
        for (int b = 0; b < BEATS; b++) begin
            if (beat == BEAT_W'(b)) sel = data[b*PER_BEAT +: PER_BEAT];
        end
    end

endmodule

// File: rtl/axis_conv_out_pipe.sv
// Two-slot ping-pong buffer behind the conv engine, serialised into CONV_CORES/CORES_PER_BEAT AXIS beats.
// Beat 0 one cycle after accept; s_ready is registered state only. CONV_OUT_RELU_EN clamps negative words at write.
module axis_conv_out_pipe
    import conv_out_pkg::*;
#(
    parameter int CONV_CORES     = 24,
    parameter int CONV_UNITS     = 8,
    parameter int WORD_WIDTH     = 25,
    parameter int CORES_PER_BEAT = 4,
    parameter int TUSER_WIDTH    = 4,
    parameter int INDEX_IS_RELU  = 2
) (
    input  logic                                                    aclk,
    input  logic                                                    aresetn,
    input  logic                                                    s_valid,
    output logic                                                    s_ready,
    input  logic [CONV_CORES-1:0][CONV_UNITS-1:0][WORD_WIDTH-1:0]     s_data,
    input  logic                                                    s_last,
    input  logic [TUSER_WIDTH-1:0]                                  s_user,
    output logic                                                    m_tvalid,
    input  logic                                                    m_tready,
    output logic [CORES_PER_BEAT-1:0][CONV_UNITS-1:0][WORD_WIDTH-1:0] m_tdata,
    output logic                                                    m_tlast,
    output logic [TUSER_WIDTH-1:0]                                  m_tuser
);

    localparam int BEATS  = calc_beats(CONV_CORES, CORES_PER_BEAT);
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    if ((CONV_CORES % CORES_PER_BEAT) != 0) begin : g_bad_split
        $error("CORES_PER_BEAT must divide CONV_CORES");
    end
    if (INDEX_IS_RELU >= TUSER_WIDTH) begin : g_bad_relu_idx
        $error("INDEX_IS_RELU outside TUSER_WIDTH");
    end

    typedef logic [CONV_CORES-1:0][CONV_UNITS-1:0][WORD_WIDTH-1:0] arr_t;
    typedef struct packed {
        arr_t                   data;
        logic                   last;
        logic [TUSER_WIDTH-1:0] user;
    } buf_t;

    buf_t                slot [2];
    buf_t                rd_slot;
    buf_t                wr_slot;
    arr_t                wr_data;
    logic                wr_ptr;
    logic                rd_ptr;
    logic [1:0]          count;
    logic [BEAT_W-1:0]   beat;
    logic                rst_done;
    logic                push;
    logic                pop_beat;
    logic                pop_arr;
    logic [CORES_PER_BEAT-1:0][CONV_UNITS-1:0][WORD_WIDTH-1:0] beat_data;

    assign s_ready  = rst_done & (count != 2'd2);
    assign m_tvalid = (count != 2'd0);
    assign push     = s_valid & s_ready;
    assign pop_beat = m_tvalid & m_tready;
    assign pop_arr  = pop_beat & (beat == LAST_BEAT);

`ifdef CONV_OUT_RELU_EN
    always_comb begin
        wr_data = s_data;
        if (s_user[INDEX_IS_RELU]) begin
            for (int c = 0; c < CONV_CORES; c++) begin
                for (int u = 0; u < CONV_UNITS; u++) begin
                    if (s_data[c][u][WORD_WIDTH-1]) wr_data[c][u] = '0;
                end
            end
        end
    end
`else
    assign wr_data = s_data;
`endif

    assign wr_slot.data = wr_data;
    assign wr_slot.last = s_last;
    assign wr_slot.user = s_user;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rst_done <= 1'b0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= 2'd0;
            beat     <= '0;
        end else begin
            rst_done <= 1'b1;
            if (push) wr_ptr <= ~wr_ptr;
            if (pop_arr) rd_ptr <= ~rd_ptr;
            if (pop_beat) beat <= pop_arr ? '0 : beat + 1'b1;
            case ({push, pop_arr})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Slots need no reset: every output is gated by m_tvalid, so stale contents never leak.
    always_ff @(posedge aclk) begin
        if (push) slot[wr_ptr] <= wr_slot;
    end

    assign rd_slot = slot[rd_ptr];

    conv_beat_mux #(
        .CORES      (CONV_CORES),
        .UNITS      (CONV_UNITS),
        .WORD_WIDTH (WORD_WIDTH),
        .PER_BEAT   (CORES_PER_BEAT),
        .BEAT_W     (BEAT_W)
    ) u_beat_mux (
        .data (rd_slot.data),
        .beat (beat),
        .sel  (beat_data)
    );

    assign m_tdata = m_tvalid ? beat_data : '0;
    assign m_tuser = m_tvalid ? rd_slot.user : '0;
    assign m_tlast = m_tvalid & rd_slot.last & (beat == LAST_BEAT);

endmodule
